// File: rtl/tetris_pkg.sv
// Package tetris: key index constants, per-key FSM state type and
// small elaboration-time helpers shared by the key conditioner files.
package tetris;

    // Bit positions of each button inside keys_i / level_o / pulse_o
    localparam int KEY_RESET  = 4;
    localparam int KEY_LEFT   = 3;
    localparam int KEY_RIGHT  = 2;
    localparam int KEY_ROTATE = 1;
    localparam int KEY_START  = 0;

    // Per-key command FSM; REPEAT is only reachable with auto-repeat built in
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must hold values 0..max_count
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// key_conditioner_channel: one push-button lane.
// Raw pin -> polarity normalisation -> 2-flop synchroniser -> counter
// debounce -> press pulse, plus auto-repeat while held when the build
// defines KEY_AUTO_REPEAT_EN and this lane has repeat_en_p set.
module key_conditioner_channel
    import tetris::*;
#(
    parameter int active_high_p     = 1,
    parameter int debounce_cycles_p = 4,
    parameter int repeat_delay_p    = 16,
    parameter int repeat_period_p   = 8,
    parameter bit repeat_en_p       = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic key_i,
    output logic level_o,
    output logic pulse_o
);

    localparam logic invert_lp = (active_high_p == 0);
    localparam int   deb_w_lp  = cnt_width(debounce_cycles_p);
    localparam logic [deb_w_lp-1:0] deb_last_lp = deb_w_lp'(debounce_cycles_p - 1);

    logic                pressed_raw;
    logic                sync_meta;
    logic                sync_q;
    logic                stable_q;
    logic [deb_w_lp-1:0] deb_cnt;
    logic                flip;
    logic                rise;
    logic                fall;
    logic                pulse_q;
    key_state_e          state;

    assign pressed_raw = key_i ^ invert_lp;

    // Two-flop synchroniser; resets to "not pressed" so a held key re-debounces
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= pressed_raw;
            sync_q    <= sync_meta;
        end
    end

    // Decode whether the stable level flips on the coming edge, and which way
    always_comb begin
        flip = (sync_q != stable_q) && (deb_cnt == deb_last_lp);
        rise = flip & ~stable_q;
        fall = flip & stable_q;
    end

    // Debounce: count consecutive samples disagreeing with the stable level
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stable_q <= 1'b0;
            deb_cnt  <= '0;
        end else if (sync_q == stable_q) begin
            deb_cnt <= '0;
        end else if (flip) begin
            stable_q <= ~stable_q;
            deb_cnt  <= '0;
        end else if (deb_cnt < deb_last_lp) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int rep_w_lp = cnt_width(max_int(repeat_delay_p, repeat_period_p));
    localparam logic [rep_w_lp-1:0] delay_last_lp  = rep_w_lp'(repeat_delay_p - 1);
    localparam logic [rep_w_lp-1:0] period_last_lp = rep_w_lp'(repeat_period_p - 1);

    logic [rep_w_lp-1:0] rep_cnt;

    // Command FSM: press pulse on rise, then delayed and periodic repeats while held
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            rep_cnt <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (fall) begin
                state   <= IDLE;
                rep_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        rep_cnt <= '0;
                        if (rise) begin
                            state   <= HELD;
                            pulse_q <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (repeat_en_p) begin
                            if (rep_cnt == delay_last_lp) begin
                                state   <= REPEAT;
                                rep_cnt <= '0;
                                pulse_q <= 1'b1;
                            end else if (rep_cnt < delay_last_lp) begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (rep_cnt == period_last_lp) begin
                            rep_cnt <= '0;
                            pulse_q <= 1'b1;
                        end else if (rep_cnt < period_last_lp) begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end
                endcase
            end
        end
    end
`else
    // Command FSM: a single pulse per debounced press, nothing while held
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (fall) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state   <= HELD;
                            pulse_q <= 1'b1;
                        end
                    end
                    HELD:    state <= HELD;
                    default: state <= IDLE;
                endcase
            end
        end
    end
`endif

    assign level_o = stable_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw asynchronous push-button levels into clean,
// single-cycle game commands for game_top_logic. One lane per key,
// bit order {reset,left,right,rotate,start}.
// Optional feature macro: KEY_AUTO_REPEAT_EN enables auto-repeat for keys
// selected by repeat_mask_p; without it each press yields exactly one pulse.
module key_conditioner
    import tetris::*;
#(
    parameter int width_p           = 5,
    parameter int active_high_p     = 1,
    parameter int debounce_cycles_p = 4,
    parameter int repeat_delay_p    = 16,
    parameter int repeat_period_p   = 8,
    parameter logic [width_p-1:0] repeat_mask_p =
        width_p'((1 << KEY_LEFT) | (1 << KEY_RIGHT))
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] keys_i,
    output logic [width_p-1:0] level_o,
    output logic [width_p-1:0] pulse_o
);

    // One independent conditioning lane per key
    for (genvar i = 0; i < width_p; i++) begin : g_chan
        key_conditioner_channel #(
            .active_high_p    (active_high_p),
            .debounce_cycles_p(debounce_cycles_p),
            .repeat_delay_p   (repeat_delay_p),
            .repeat_period_p  (repeat_period_p),
            .repeat_en_p      (repeat_mask_p[i])
        ) u_chan (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .key_i    (keys_i[i]),
            .level_o  (level_o[i]),
            .pulse_o  (pulse_o[i])
        );
    end

endmodule
